// File: rtl/down_sample.sv
// 2x2 decimator: keeps even-column/even-row pixels of a raster stream and
// buffers them in a small FWFT FIFO presented through a valid/rd_en pull port.
module down_sample #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              src_rd_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              busy_q, frame_done_q;

  logic accept, keep, push, pop, last_pix;

  assign src_rd_en  = (state_q == S_STREAM) && (cnt_q < CNT_FULL);
  assign valid_out  = (cnt_q != '0);
  // Gate the head so the port reads zero whenever nothing is buffered.
  assign data_out   = valid_out ? mem_q[rd_ptr_q] : '0;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  assign accept   = src_rd_en && valid_in;
  assign keep     = !col_q[0] && !row_q[0];
  assign push     = accept && keep;
  assign pop      = rd_en && valid_out;
  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Frame sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (accept && last_pix) state_d = S_DRAIN;
      S_DRAIN:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Raster position; discarded pixels still advance it
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // FIFO bookkeeping; simultaneous push and pop leaves the count unchanged
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      busy_q       <= (state_d == S_STREAM) || (state_d == S_DRAIN);
      frame_done_q <= (state_d == S_DONE);
    end
  end

  // Storage needs no reset: reads are masked by the count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: doc/down_sample.md
Name: down_sample

Overview:
- Decimating stage directly upstream of the Gaussian control stage in each octave of the SIFT pyramid.
- Pulls a raster-order 8-bit pixel stream from the previous octave's buffer or the image source.
- Keeps pixels at even column and even row (2x2 decimation) and buffers them in a small first-word-fall-through (FWFT) FIFO.
- Presents the FIFO to the Gaussian control stage through a valid/rd_en pull handshake.

Parameters:
- IMG_WIDTH, 640, input frame width in pixels (>=2)
- IMG_HEIGHT, 480, input frame height in pixels (>=2)
- DATA_W, 8, pixel width in bits
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- global_reset  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE
- data_in  input  DATA_W  pixel from upstream
- valid_in  input  1  data_in holds a valid pixel
- src_rd_en  output  1  request/accept to upstream; a pixel is consumed on a cycle where src_rd_en && valid_in
- rd_en  input  1  pop request from Gaussian control
- data_out  output  DATA_W  FIFO head, valid when valid_out=1
- valid_out  output  1  FIFO non-empty
- busy  output  1  high in STREAM or DRAIN
- frame_done  output  1  one-cycle pulse after the last decimated pixel of a frame has been popped

Behaviour:
- Reset (global_reset=1 at a clock edge): state=IDLE, col=0, row=0, FIFO pointers and count=0, src_rd_en=0, valid_out=0, data_out=0, busy=0, frame_done=0. Reset overrides all other inputs, including mid-frame; partial-frame data is discarded.
- States:
  - IDLE: start=1 -> STREAM.
  - STREAM: when the pixel at (col=IMG_WIDTH-1, row=IMG_HEIGHT-1) is accepted -> DRAIN.
  - DRAIN: FIFO count==0 -> DONE.
  - DONE: one cycle, frame_done=1 -> IDLE.
  - start outside IDLE is ignored.
- src_rd_en = (state==STREAM) && (count < FIFO_DEPTH); registered-free combinational from state and count.
- Accept = src_rd_en && valid_in. On accept:
  - Pixel kept iff col[0]==0 && row[0]==0.
  - col increments; at IMG_WIDTH-1, col wraps to 0 and row increments; at the last pixel, row wraps to 0.
  - Discarded pixels still advance the counters.
- Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits. Output pixels per frame = ceil(W/2)*ceil(H/2).
- Push = accept && kept. Pop = rd_en && valid_out; rd_en while empty is ignored, with no underflow and no pointer change.
- Simultaneous push and pop: count unchanged, both pointers advance, legal at any occupancy including full. Full blocks only new acceptance, through src_rd_en=0.
- Latency: a kept pixel accepted at edge N is on data_out with valid_out=1 after edge N (visible in cycle N+1) if the FIFO was empty. data_out is held stable while valid_out=1 and rd_en=0.
- busy = state is STREAM or DRAIN.
- frame_done rises the cycle after the FIFO empties in DRAIN. A new start is accepted the cycle after frame_done.

Test Plan:
- 4x4 frame, values 0..15, valid_in=1, rd_en=1 -> data_out sequence 0,2,8,10; exactly 4 pops; frame_done one cycle after the last pop; busy low afterwards.
- Same frame with rd_en=0 -> FIFO holds 0,2,8,10 (count 4); src_rd_en=0 from then on; upstream stalls at pixel 11; releasing rd_en drains 0,2,8,10 in order.
- 5x3 frame (parameters overridden), values 0..14 -> outputs 0,2,4,10,12,14 (6 pixels), then frame_done.
- valid_in toggling 1,0,1,0 with rd_en=1 -> counters advance only on accepted cycles; output identical to the first scenario.
- global_reset asserted in STREAM after 6 pixels with 2 in the FIFO -> next cycle valid_out=0, src_rd_en=0, busy=0; a fresh start on the 4x4 frame yields 0,2,8,10.
- start pulsed while busy, and rd_en pulsed while empty -> no state change, no output, count unchanged.
